aes_sbox_arbiter: RTL and testbench

- Shares one 32-bit-wide S-box (four parallel byte S-boxes, combinational) between two requesters: port 0 = key memory/expansion, port 1 = encipher round datapath.
- Registered, round-robin grant with a hold-while-requested lock and an optional burst limit.
- Sits in the core between the key memory, the encipher round logic and the single S-box instance.
- Replaces the ad-hoc S-box mux currently driven by the core's top-level FSM.

---
 rtl/aes_sbox_arbiter_if.sv | 25 ++
 rtl/aes_sbox_arbiter.sv | 110 +++++++++++
 tb/tb_aes_sbox_arbiter.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/aes_sbox_arbiter_if.sv
// rtl/aes_sbox_arbiter_if.sv - requester, S-box and statistics signals of the shared S-box arbiter
interface aes_sbox_arbiter_if;
   logic        req0;
   logic [31:0] word0;
   logic        gnt0;
   logic        req1;
   logic [31:0] word1;
   logic        gnt1;
   logic [31:0] sboxw;
   logic [31:0] new_sboxw;
   logic [31:0] result;
   logic        busy;
   logic [15:0] gnt_cnt0;
   logic [15:0] gnt_cnt1;

   modport slave (
      input  req0, word0, req1, word1, new_sboxw,
      output gnt0, gnt1, sboxw, result, busy, gnt_cnt0, gnt_cnt1
   );

   modport master (
      output req0, word0, req1, word1, new_sboxw,
      input  gnt0, gnt1, sboxw, result, busy, gnt_cnt0, gnt_cnt1
   );
endinterface

// File: rtl/aes_sbox_arbiter.sv
// rtl/aes_sbox_arbiter.sv - round-robin S-box arbiter with burst limit; grant counters under AES_SBOX_ARB_STATS_EN
module aes_sbox_arbiter #(
   parameter int MAX_BURST = 4,
   parameter int CTR_W     = 3
) (
   input  logic               clk,
   input  logic               reset_n,
   aes_sbox_arbiter_if.slave  bus
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] GNT0 = 2'd1;
   localparam logic [1:0] GNT1 = 2'd2;

   localparam logic [CTR_W-1:0] BURST_LAST = (MAX_BURST == 0) ? '0 : CTR_W'(MAX_BURST - 1);
   localparam logic             BURST_ON   = (MAX_BURST != 0);

   logic [1:0]       state;
   logic [1:0]       state_nxt;
   logic [CTR_W-1:0] burst_ctr;
   logic [CTR_W-1:0] ctr_nxt;
   logic             last_gnt;
   logic             gnt0_q;
   logic             gnt1_q;
   logic             busy_q;
   logic             own_req;
   logic             other_req;

   assign own_req   = (state == GNT0) ? bus.req0 : bus.req1;
   assign other_req = (state == GNT0) ? bus.req1 : bus.req0;

   always_comb begin
      state_nxt = state;
      ctr_nxt   = '0;
      case (state)
         IDLE: begin
            if (bus.req0 && bus.req1)
               state_nxt = last_gnt ? GNT0 : GNT1;
            else if (bus.req0)
               state_nxt = GNT0;
            else if (bus.req1)
               state_nxt = GNT1;
         end
         GNT0, GNT1: begin
            if (!own_req)
               state_nxt = other_req ? ((state == GNT0) ? GNT1 : GNT0) : IDLE;
            else if (other_req && BURST_ON && burst_ctr == BURST_LAST)
               state_nxt = (state == GNT0) ? GNT1 : GNT0;
            else if (BURST_ON && burst_ctr != BURST_LAST)
               ctr_nxt = burst_ctr + 1'b1;
            else
               // saturated: a newly arriving request is served after one more cycle
               ctr_nxt = burst_ctr;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // grant outputs are registered copies of the next state so they never glitch
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         burst_ctr <= '0;
         last_gnt  <= 1'b1;
         gnt0_q    <= 1'b0;
         gnt1_q    <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state     <= state_nxt;
         burst_ctr <= ctr_nxt;
         gnt0_q    <= (state_nxt == GNT0);
         gnt1_q    <= (state_nxt == GNT1);
         busy_q    <= (state_nxt != IDLE);
         if (state_nxt == GNT0)
            last_gnt <= 1'b0;
         else if (state_nxt == GNT1)
            last_gnt <= 1'b1;
      end
   end

   assign bus.gnt0   = gnt0_q;
   assign bus.gnt1   = gnt1_q;
   assign bus.busy   = busy_q;
   assign bus.sboxw  = gnt0_q ? bus.word0 : (gnt1_q ? bus.word1 : 32'h0);
   assign bus.result = bus.new_sboxw;

`ifdef AES_SBOX_ARB_STATS_EN
   logic [15:0] cnt0;
   logic [15:0] cnt1;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt0 <= 16'h0;
         cnt1 <= 16'h0;
      end else begin
         if (gnt0_q && cnt0 != 16'hffff)
            cnt0 <= cnt0 + 16'd1;
         if (gnt1_q && cnt1 != 16'hffff)
            cnt1 <= cnt1 + 16'd1;
      end
   end

   assign bus.gnt_cnt0 = cnt0;
   assign bus.gnt_cnt1 = cnt1;
`else
   assign bus.gnt_cnt0 = 16'h0;
   assign bus.gnt_cnt1 = 16'h0;
`endif

endmodule

// File: tb/tb_aes_sbox_arbiter.sv
// tb/tb_aes_sbox_arbiter.sv - directed bench for aes_sbox_arbiter (burst-limited and unlimited instances)
module tb_aes_sbox_arbiter;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   aes_sbox_arbiter_if bus_a ();
   aes_sbox_arbiter_if bus_b ();

   // stand-in S-box: bitwise inversion, so expected results are easy to hand-compute
   assign bus_a.new_sboxw = ~bus_a.sboxw;
   assign bus_b.new_sboxw = ~bus_b.sboxw;

   aes_sbox_arbiter #(.MAX_BURST(4), .CTR_W(3)) u_dut_a (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus_a)
   );

   aes_sbox_arbiter #(.MAX_BURST(0), .CTR_W(3)) u_dut_b (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus_b)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset_n    = 1'b0;
      bus_a.req0 = 1'b0;
      bus_a.req1 = 1'b0;
      bus_b.req0 = 1'b0;
      bus_b.req1 = 1'b0;
      tick();
      reset_n = 1'b1;
   endtask

   initial begin
      bus_a.word0 = 32'h0;
      bus_a.word1 = 32'h0;
      bus_b.word0 = 32'h0;
      bus_b.word1 = 32'h0;
      do_reset();

      // reset state
      check("rst_gnt0", bus_a.gnt0, 0);
      check("rst_gnt1", bus_a.gnt1, 0);
      check("rst_busy", bus_a.busy, 0);
      check("rst_sboxw", bus_a.sboxw, 32'h0);
      check("rst_cnt0", bus_a.gnt_cnt0, 0);
      check("rst_cnt1", bus_a.gnt_cnt1, 0);

      // single request: one edge of latency
      bus_a.req0  = 1'b1;
      bus_a.word0 = 32'h00112233;
      #1;
      check("lat_pre_gnt0", bus_a.gnt0, 0);
      tick();
      check("single_gnt0", bus_a.gnt0, 1);
      check("single_gnt1", bus_a.gnt1, 0);
      check("single_busy", bus_a.busy, 1);
      check("single_sboxw", bus_a.sboxw, 32'h00112233);
      check("single_result", bus_a.result, 32'hffeeddcc);
      bus_a.req0 = 1'b0;
      tick();
      check("release_gnt0", bus_a.gnt0, 0);
      check("release_busy", bus_a.busy, 0);
      check("idle_sboxw", bus_a.sboxw, 32'h0);

      // tie after reset goes to port 0, then direct handover to port 1
      do_reset();
      bus_a.req0  = 1'b1;
      bus_a.req1  = 1'b1;
      bus_a.word1 = 32'ha5a5a5a5;
      tick();
      check("tie_gnt0", bus_a.gnt0, 1);
      check("tie_gnt1", bus_a.gnt1, 0);
      bus_a.req0 = 1'b0;
      tick();
      check("handover_gnt0", bus_a.gnt0, 0);
      check("handover_gnt1", bus_a.gnt1, 1);
      check("handover_busy", bus_a.busy, 1);
      check("handover_sboxw", bus_a.sboxw, 32'ha5a5a5a5);
      check("handover_result", bus_a.result, 32'h5a5a5a5a);
      bus_a.req1 = 1'b0;
      tick();
      check("handover_idle", bus_a.busy, 0);

      // both held: strict 4-cycle bursts, port 0 first (last grant was port 1)
      bus_a.req0 = 1'b1;
      bus_a.req1 = 1'b1;
      for (int i = 1; i <= 16; i++) begin
         logic e0;
         tick();
         e0 = (i <= 4) || (i >= 9 && i <= 12);
         check($sformatf("burst_gnt0_%0d", i), bus_a.gnt0, e0);
         check($sformatf("burst_gnt1_%0d", i), bus_a.gnt1, !e0);
         check($sformatf("burst_ctr_%0d", i), 32'(u_dut_a.burst_ctr < 3'd4), 1);
      end
      bus_a.req0 = 1'b0;
      bus_a.req1 = 1'b0;
      tick();
      check("burst_end_busy", bus_a.busy, 0);

      // unlimited burst: req1 held 20 cycles, req0 waits until req1 drops
      do_reset();
      bus_b.req1 = 1'b1;
      for (int i = 1; i <= 20; i++) begin
         tick();
         if (i == 3)
            bus_b.req0 = 1'b1;
         check($sformatf("unl_gnt1_%0d", i), bus_b.gnt1, 1);
         check($sformatf("unl_gnt0_%0d", i), bus_b.gnt0, 0);
      end
      bus_b.req1 = 1'b0;
      tick();
      check("unl_after_gnt0", bus_b.gnt0, 1);
      check("unl_after_gnt1", bus_b.gnt1, 0);
      bus_b.req0 = 1'b0;

      // grant statistics: 10 cycles of gnt0 then 7 cycles of gnt1
      do_reset();
      bus_a.req0 = 1'b1;
      repeat (10) tick();
      bus_a.req0 = 1'b0;
      bus_a.req1 = 1'b1;
      repeat (7) tick();
      bus_a.req1 = 1'b0;
      tick();
      check("stats_idle", bus_a.busy, 0);
`ifdef AES_SBOX_ARB_STATS_EN
      check("stats_cnt0", bus_a.gnt_cnt0, 10);
      check("stats_cnt1", bus_a.gnt_cnt1, 7);
`else
      check("stats_cnt0_off", bus_a.gnt_cnt0, 0);
      check("stats_cnt1_off", bus_a.gnt_cnt1, 0);
`endif

      // async reset mid-grant drops outputs before the next edge
      do_reset();
      bus_a.req1 = 1'b1;
      tick();
      check("pre_areset_gnt1", bus_a.gnt1, 1);
      #2;
      reset_n = 1'b0;
      #1;
      check("areset_gnt1", bus_a.gnt1, 0);
      check("areset_busy", bus_a.busy, 0);
      check("areset_sboxw", bus_a.sboxw, 32'h0);
      #1;
      reset_n    = 1'b1;
      bus_a.req0 = 1'b1;
      tick();
      check("post_areset_tie_gnt0", bus_a.gnt0, 1);
      check("post_areset_tie_gnt1", bus_a.gnt1, 0);
      bus_a.req0 = 1'b0;
      bus_a.req1 = 1'b0;
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
